// File: rtl/fp_norm_round.sv
// fp_norm_round
//   Sequential normalise-and-round back end for the binary32 multiplier.
//   Takes the raw sign, biased exponent sum and 48-bit mantissa product,
//   normalises one bit per cycle, denormalises into the subnormal range,
//   applies round-to-nearest-even and packs the binary32 result.
//
// Ports
//   i_clk      clock, rising edge
//   i_rst      asynchronous active-high reset
//   i_start    load operands (accepted only while o_busy=0)
//   i_sign     result sign
//   i_exp      signed biased exponent, value = i_mant * 2^(i_exp-127-46)
//   i_mant     raw 48-bit product, bit 46 is the nominal leading one
//   i_special  00 normal, 01 zero, 10 infinity, 11 NaN
//   o_res      packed binary32 result, held until the next pack
//   o_busy     high from the accepting edge until o_done is raised
//   o_done     one-cycle pulse when o_res is updated
//   o_flags    {overflow, underflow, inexact}, only with FP_FLAGS_EN
//
// Build option
//   FP_FLAGS_EN  adds the o_flags output and its register.

module fp_norm_round #(
  parameter int EXP_W     = 10,
  parameter int MANT_W    = 48,
  parameter int FLUSH_LIM = -24
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_sign,
  input  logic [EXP_W-1:0]  i_exp,
  input  logic [MANT_W-1:0] i_mant,
  input  logic [1:0]        i_special,
  output logic [31:0]       o_res,
  output logic              o_busy,
  output logic              o_done
`ifdef FP_FLAGS_EN
  ,
  output logic [2:0]        o_flags
`endif
);

  // Two guard bits on the exponent so shifting and rounding never wrap.
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
  localparam logic signed [XW-1:0] EXP_MAX  = XW'(255);
  localparam logic signed [XW-1:0] EXP_LIM  = XW'(FLUSH_LIM);

  typedef enum logic [2:0] {IDLE, SHR, SHL, DENORM, ROUND, PACK} stateT;

  stateT                   r_state, w_stateNext;
  logic                    r_sign, w_signNext;
  logic [1:0]              r_special, w_specialNext;
  logic                    r_zero, w_zeroNext;
  logic [MANT_W-1:0]       r_mant, w_mantNext;
  logic signed [XW-1:0]    r_exp, w_expNext;
  logic                    r_sticky, w_stickyNext;
  logic [23:0]             r_kept, w_keptNext;
  logic                    r_inexact, w_inexactNext;
  logic [31:0]             r_res, w_resNext;
  logic                    r_busy, w_busyNext;
  logic                    r_done, w_doneNext;

  // Rounding terms, evaluated from the normalised mantissa in ROUND.
  logic        w_guard;
  logic        w_roundSticky;
  logic        w_roundUp;
  logic [24:0] w_sum;

  assign w_guard       = r_mant[22];
  assign w_roundSticky = r_sticky | (|r_mant[21:0]);
  assign w_roundUp     = w_guard & (w_roundSticky | r_mant[23]);
  assign w_sum         = {1'b0, r_mant[46:23]} + {24'b0, w_roundUp};

  // Result classification used in PACK; specials take priority.
  logic w_isNan, w_isInf, w_isZero, w_isOvf, w_isSub;

  assign w_isNan  = (r_special == 2'b11);
  assign w_isInf  = (r_special == 2'b10);
  assign w_isZero = !r_special[1] && (r_zero || (r_kept == 24'd0));
  assign w_isOvf  = !r_special[1] && !w_isZero && (r_exp >= EXP_MAX);
  assign w_isSub  = !r_special[1] && !w_isZero && !w_isOvf && !r_kept[23];

  always_comb begin
    w_stateNext   = r_state;
    w_signNext    = r_sign;
    w_specialNext = r_special;
    w_zeroNext    = r_zero;
    w_mantNext    = r_mant;
    w_expNext     = r_exp;
    w_stickyNext  = r_sticky;
    w_keptNext    = r_kept;
    w_inexactNext = r_inexact;
    w_resNext     = r_res;
    w_busyNext    = r_busy;
    w_doneNext    = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_signNext    = i_sign;
          w_specialNext = i_special;
          w_zeroNext    = (i_special == 2'b01) || (i_mant == '0);
          w_mantNext    = i_mant;
          w_expNext     = {{2{i_exp[EXP_W-1]}}, i_exp};
          w_stickyNext  = 1'b0;
          w_inexactNext = 1'b0;
          w_busyNext    = 1'b1;
          if (i_special != 2'b00 || i_mant == '0) w_stateNext = PACK;
          else                                    w_stateNext = SHR;
        end
      end

      SHR: begin
        if (r_mant[47]) begin
          w_mantNext   = {1'b0, r_mant[MANT_W-1:1]};
          w_expNext    = r_exp + EXP_ONE;
          w_stickyNext = r_sticky | r_mant[0];
        end else begin
          w_stateNext = SHL;
        end
      end

      SHL: begin
        if (!r_mant[46] && r_exp > EXP_ONE) begin
          w_mantNext = {r_mant[MANT_W-2:0], 1'b0};
          w_expNext  = r_exp - EXP_ONE;
        end else begin
          w_stateNext = DENORM;
        end
      end

      // Far below the subnormal range everything lands in sticky, so the
      // whole mantissa is collapsed at once instead of shifting bit by bit.
      DENORM: begin
        if (r_exp <= EXP_LIM) begin
          w_stickyNext = r_sticky | (|r_mant);
          w_mantNext   = '0;
          w_expNext    = EXP_ONE;
          w_stateNext  = ROUND;
        end else if (r_exp < EXP_ONE) begin
          w_mantNext   = {1'b0, r_mant[MANT_W-1:1]};
          w_expNext    = r_exp + EXP_ONE;
          w_stickyNext = r_sticky | r_mant[0];
        end else begin
          w_stateNext = ROUND;
        end
      end

      // A carry out of 24 bits leaves 1000...0, so the dropped bit is zero.
      ROUND: begin
        w_stickyNext  = w_roundSticky;
        w_inexactNext = w_guard | w_roundSticky;
        if (w_sum[24]) begin
          w_keptNext = w_sum[24:1];
          w_expNext  = r_exp + EXP_ONE;
        end else begin
          w_keptNext = w_sum[23:0];
        end
        w_stateNext = PACK;
      end

      PACK: begin
        if (w_isNan)       w_resNext = 32'hFFFF_FFFF;
        else if (w_isInf)  w_resNext = {r_sign, 8'hFF, 23'd0};
        else if (w_isZero) w_resNext = {r_sign, 31'd0};
        else if (w_isOvf)  w_resNext = {r_sign, 8'hFF, 23'd0};
        else if (w_isSub)  w_resNext = {r_sign, 8'h00, r_kept[22:0]};
        else               w_resNext = {r_sign, r_exp[7:0], r_kept[22:0]};
        w_doneNext  = 1'b1;
        w_busyNext  = 1'b0;
        w_stateNext = IDLE;
      end

      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_sign    <= 1'b0;
      r_special <= 2'b00;
      r_zero    <= 1'b0;
      r_mant    <= '0;
      r_exp     <= '0;
      r_sticky  <= 1'b0;
      r_kept    <= '0;
      r_inexact <= 1'b0;
      r_res     <= 32'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_sign    <= w_signNext;
      r_special <= w_specialNext;
      r_zero    <= w_zeroNext;
      r_mant    <= w_mantNext;
      r_exp     <= w_expNext;
      r_sticky  <= w_stickyNext;
      r_kept    <= w_keptNext;
      r_inexact <= w_inexactNext;
      r_res     <= w_resNext;
      r_busy    <= w_busyNext;
      r_done    <= w_doneNext;
    end
  end

  assign o_res  = r_res;
  assign o_busy = r_busy;
  assign o_done = r_done;

`ifdef FP_FLAGS_EN
  // An overflowed result is never exact, so overflow also raises inexact.
  logic [2:0] r_flags;
  logic [2:0] w_flagsNext;

  assign w_flagsNext = {w_isOvf, (w_isZero | w_isSub) & r_inexact, r_inexact | w_isOvf};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                r_flags <= 3'b000;
    else if (r_state == PACK) r_flags <= w_flagsNext;
  end

  assign o_flags = r_flags;
`endif

endmodule

// File: tb/tb_fp_norm_round.sv
// Self-checking bench for fp_norm_round. Expected results are queued when an
// operation is started and compared by a monitor whenever o_done pulses.

module tb_fp_norm_round;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic        i_sign;
  logic [9:0]  i_exp;
  logic [47:0] i_mant;
  logic [1:0]  i_special;
  logic [31:0] o_res;
  logic        o_busy;
  logic        o_done;
`ifdef FP_FLAGS_EN
  logic [2:0]  o_flags;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] expQ[$];
  logic [2:0]  flagQ[$];
  string       tagQ[$];

  fp_norm_round dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_sign    (i_sign),
    .i_exp     (i_exp),
    .i_mant    (i_mant),
    .i_special (i_special),
    .o_res     (o_res),
    .o_busy    (o_busy),
`ifdef FP_FLAGS_EN
    .o_flags   (o_flags),
`endif
    .o_done    (o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Scoreboard monitor: every o_done pulse consumes one queued expectation.
  always @(negedge i_clk) begin
    if (!i_rst && o_done) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected o_done", 32'd1, 32'd0);
      end else begin
        string       t;
        logic [31:0] e;
        logic [2:0]  f;
        t = tagQ.pop_front();
        e = expQ.pop_front();
        f = flagQ.pop_front();
        checkOutput(t, o_res, e);
`ifdef FP_FLAGS_EN
        checkOutput({t, " flags"}, {29'd0, o_flags}, {29'd0, f});
`else
        if (f === 3'bxxx) $display("[TB] flags unknown for %s", t);
`endif
      end
    end
  end

  // Starts one operation and waits for o_done. Edges are counted with the
  // accepting edge as edge 1. pokeBusy drives a conflicting i_start while busy.
  task automatic applyStimulus(input string tag, input logic sign, input logic [9:0] expIn,
                               input logic [47:0] mant, input logic [1:0] special,
                               input logic [31:0] expRes, input logic [2:0] expFlags,
                               input bit pokeBusy, output int edges);
    int waitCnt;
    waitCnt = 0;
    while (o_busy && waitCnt < 100) begin
      @(negedge i_clk);
      waitCnt++;
    end
    if (o_busy) checkOutput({tag, " idle wait"}, 32'd1, 32'd0);
    @(negedge i_clk);
    i_start   = 1'b1;
    i_sign    = sign;
    i_exp     = expIn;
    i_mant    = mant;
    i_special = special;
    tagQ.push_back(tag);
    expQ.push_back(expRes);
    flagQ.push_back(expFlags);
    edges = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge i_clk);
      edges++;
      #1;
      i_start = 1'b0;
      if (pokeBusy && edges == 3) begin
        i_start   = 1'b1;
        i_sign    = 1'b1;
        i_special = 2'b11;
        i_mant    = 48'd0;
      end
      if (o_done) break;
    end
    if (!o_done) begin
      checkOutput({tag, " done timeout"}, 32'd0, 32'd1);
      i_rst = 1'b1;
      #2;
      i_rst = 1'b0;
      tagQ.delete();
      expQ.delete();
      flagQ.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int e;
    i_rst     = 1'b1;
    i_start   = 1'b0;
    i_sign    = 1'b0;
    i_exp     = 10'd0;
    i_mant    = 48'd0;
    i_special = 2'b00;
    repeat (2) @(negedge i_clk);
    checkOutput("reset o_res", o_res, 32'd0);
    checkOutput("reset o_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("reset o_done", {31'd0, o_done}, 32'd0);
    i_rst = 1'b0;

    applyStimulus("basic -0.25", 1'b1, 10'd125, 48'h4000_0000_0000, 2'b00, 32'hBE80_0000, 3'b000, 1'b0, e);
    applyStimulus("shr 193.375", 1'b0, 10'd133, 48'hC160_0000_0000, 2'b00, 32'h4341_6000, 3'b000, 1'b0, e);
    applyStimulus("overflow", 1'b0, 10'd254, 48'h8000_0000_0000, 2'b00, 32'h7F80_0000, 3'b101, 1'b0, e);
    applyStimulus("subnormal", 1'b0, -10'sd1, 48'h4000_0000_0000, 2'b00, 32'h0020_0000, 3'b000, 1'b0, e);
    applyStimulus("flush", 1'b0, -10'sd40, 48'h4000_0000_0000, 2'b00, 32'h0000_0000, 3'b011, 1'b0, e);
    checkOutput("flush latency le 6", {31'd0, (e <= 6)}, 32'd1);
    applyStimulus("rne tie even", 1'b0, 10'd127, 48'h4000_0040_0000, 2'b00, 32'h3F80_0000, 3'b001, 1'b0, e);
    applyStimulus("rne tie odd", 1'b0, 10'd127, 48'h4000_00C0_0000, 2'b00, 32'h3F80_0002, 3'b001, 1'b0, e);
    applyStimulus("rne carry", 1'b0, 10'd127, 48'h7FFF_FFFF_FFFF, 2'b00, 32'h4000_0000, 3'b001, 1'b0, e);
    applyStimulus("nan", 1'b1, 10'd127, 48'h4000_0000_0000, 2'b11, 32'hFFFF_FFFF, 3'b000, 1'b0, e);
    checkOutput("nan latency", e, 32'd2);
    applyStimulus("zero special", 1'b1, 10'd127, 48'h4000_0000_0000, 2'b01, 32'h8000_0000, 3'b000, 1'b0, e);
    applyStimulus("inf special", 1'b1, 10'd3, 48'h4000_0000_0000, 2'b10, 32'hFF80_0000, 3'b000, 1'b0, e);
    applyStimulus("zero mantissa", 1'b0, 10'd127, 48'h0000_0000_0000, 2'b00, 32'h0000_0000, 3'b000, 1'b0, e);
    checkOutput("zero mantissa latency", e, 32'd2);
    applyStimulus("shl 1.0", 1'b0, 10'd133, 48'h0100_0000_0000, 2'b00, 32'h3F80_0000, 3'b000, 1'b0, e);
    applyStimulus("sub rounds to normal", 1'b0, 10'd0, 48'h7FFF_FFFF_FFFF, 2'b00, 32'h0080_0000, 3'b001, 1'b0, e);
    applyStimulus("round overflow", 1'b0, 10'd254, 48'h7FFF_FFFF_FFFF, 2'b00, 32'h7F80_0000, 3'b101, 1'b0, e);
    applyStimulus("start while busy", 1'b0, 10'd100, 48'h0000_0000_0001, 2'b00, 32'h1B00_0000, 3'b000, 1'b1, e);
    repeat (6) @(negedge i_clk);
    checkOutput("busy ignored no restart", {31'd0, o_busy}, 32'd0);

    // Abort a long left-normalisation with an asynchronous reset.
    @(negedge i_clk);
    i_start   = 1'b1;
    i_sign    = 1'b0;
    i_exp     = 10'd100;
    i_mant    = 48'd1;
    i_special = 2'b00;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (5) @(posedge i_clk);
    #3;
    i_rst = 1'b1;
    #1;
    checkOutput("mid-shl reset o_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("mid-shl reset o_res", o_res, 32'd0);
    checkOutput("mid-shl reset o_done", {31'd0, o_done}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    applyStimulus("after reset", 1'b1, 10'd125, 48'h4000_0000_0000, 2'b00, 32'hBE80_0000, 3'b000, 1'b0, e);
    repeat (4) @(negedge i_clk);
    checkOutput("scoreboard drained", expQ.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
